// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared SNN helpers (saturation, index width, reset modes).
//  Revision    : 1.0
// ============================================================================
package snn_pkg;

    localparam int RST_ZERO = 0;
    localparam int RST_SUB  = 1;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

    function automatic logic signed [31:0] sat_unsigned(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< w) - 32'sd1;
        if (v > hi)
            return hi;
        else if (v < 32'sd0)
            return 32'sd0;
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/weighted_spk_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : weighted_spk_accumulator
//  Description : Combinational signed sum of the weights whose spike is high.
//  Revision    : 1.0
// ============================================================================
module weighted_spk_accumulator
    import snn_pkg::*;
#(
    parameter int NUM_FAN_IN = 8,
    parameter int W_W        = 4,
    parameter int SUM_W      = 12
) (
    input  logic [NUM_FAN_IN-1:0]     fan_in,
    input  logic [NUM_FAN_IN*W_W-1:0] weights,
    output logic signed [SUM_W-1:0]   syn
);

    logic signed [SUM_W-1:0] w_ext [NUM_FAN_IN];
    logic signed [SUM_W-1:0] w_acc;

    for (genvar i = 0; i < NUM_FAN_IN; i++) begin : g_ext
        assign w_ext[i] = SUM_W'(signed'(weights[i*W_W +: W_W]));
    end

    always_comb begin
        w_acc = '0;
        for (int i = 0; i < NUM_FAN_IN; i++) begin
            if (fan_in[i])
                w_acc = w_acc + w_ext[i];
        end
    end

    assign syn = w_acc;

endmodule
`default_nettype wire

// File: rtl/adaptive_lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : adaptive_lif_neuron
//  Description : Adaptive-threshold LIF output neuron with programmable weights.
//  Revision    : 1.0
// ============================================================================
module adaptive_lif_neuron
    import snn_pkg::*;
#(
    parameter int NUM_FAN_IN      = 8,
    parameter int DATA_W          = 8,
    parameter int W_W             = 4,
    parameter int WEIGHT_INIT     = 1,
    parameter int ORI_THR         = 32,
    parameter int DECAY_SHIFT_CUR = 2,
    parameter int DECAY_SHIFT_MEM = 2,
    parameter int DECAY_SHIFT_THR = 2,
    parameter int ADP_THR         = 2,
    parameter int REFRAC          = 2,
    parameter int RESET_MODE      = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             step,
    input  logic [NUM_FAN_IN-1:0]            fan_in,
    input  logic                             w_we,
    input  logic [idx_w(NUM_FAN_IN)-1:0]     w_addr,
    input  logic signed [W_W-1:0]            w_data,
    output logic                             spk,
    output logic signed [DATA_W-1:0]         cur_out,
    output logic signed [DATA_W-1:0]         mem_out,
    output logic [DATA_W-1:0]                thr_out,
    output logic                             refrac_out
);

    localparam int IDX_W = idx_w(NUM_FAN_IN);
    localparam int SUM_W = DATA_W + IDX_W + 1;
    localparam int REF_W = idx_w(REFRAC + 1);
    localparam logic [DATA_W-1:0] C_ORI_THR = DATA_W'(ORI_THR);

    logic signed [DATA_W-1:0] r_cur;
    logic signed [DATA_W-1:0] r_mem;
    logic [DATA_W-1:0]        r_thr;
    logic                     r_spk;
    logic [REF_W-1:0]         r_ref;
    logic signed [W_W-1:0]    r_w [NUM_FAN_IN];

    logic [NUM_FAN_IN*W_W-1:0] w_wvec;
    logic signed [SUM_W-1:0]   w_syn;
    logic signed [DATA_W-1:0]  w_cur_n;
    logic signed [DATA_W-1:0]  w_mem_s;
    logic signed [DATA_W-1:0]  w_mem_c;
    logic signed [DATA_W-1:0]  w_mem_fire;
    logic [DATA_W-1:0]         w_dec;
    logic [DATA_W-1:0]         w_thr_d;
    logic [DATA_W-1:0]         w_thr_fire;
    logic                      w_refrac;
    logic                      w_fire;

    for (genvar i = 0; i < NUM_FAN_IN; i++) begin : g_flat
        assign w_wvec[i*W_W +: W_W] = r_w[i];
    end

    weighted_spk_accumulator #(
        .NUM_FAN_IN (NUM_FAN_IN),
        .W_W        (W_W),
        .SUM_W      (SUM_W)
    ) u_acc (
        .fan_in  (fan_in),
        .weights (w_wvec),
        .syn     (w_syn)
    );

    assign w_refrac = (r_ref != '0);

    always_comb begin
        w_cur_n = DATA_W'(sat_signed(32'(r_cur) - (32'(r_cur) >>> DECAY_SHIFT_CUR) + 32'(w_syn), DATA_W));
        w_mem_s = DATA_W'(sat_signed(32'(r_mem) - (32'(r_mem) >>> DECAY_SHIFT_MEM) + 32'(w_cur_n), DATA_W));
        w_mem_c = '0;
        w_fire  = 1'b0;
        if (!w_refrac) begin
            w_mem_c = w_mem_s[DATA_W-1] ? '0 : w_mem_s;
            w_fire  = ($unsigned(w_mem_c) >= r_thr);
        end

        // Relaxation always moves by at least one so thr reaches rest.
        w_dec   = '0;
        w_thr_d = C_ORI_THR;
        if (r_thr > C_ORI_THR) begin
            w_dec = (r_thr - C_ORI_THR) >> DECAY_SHIFT_THR;
            if (w_dec == '0)
                w_dec = DATA_W'(1);
            w_thr_d = r_thr - w_dec;
        end
        w_thr_fire = DATA_W'(sat_unsigned(32'(w_thr_d) + 32'(ADP_THR), DATA_W));

        // A firing mem_c is at least thr, so thr fits the signed range here.
        w_mem_fire = (RESET_MODE == RST_ZERO) ? '0 : w_mem_c - $signed(r_thr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur <= '0;
            r_mem <= '0;
            r_thr <= C_ORI_THR;
            r_spk <= 1'b0;
            r_ref <= '0;
            for (int i = 0; i < NUM_FAN_IN; i++)
                r_w[i] <= W_W'(WEIGHT_INIT);
        end else begin
            r_spk <= 1'b0;
            if (step) begin
                r_cur <= w_cur_n;
                if (w_fire) begin
                    r_spk <= 1'b1;
                    r_mem <= w_mem_fire;
                    r_thr <= w_thr_fire;
                    r_ref <= REF_W'(REFRAC);
                end else begin
                    r_mem <= w_mem_c;
                    r_thr <= w_thr_d;
                    if (w_refrac)
                        r_ref <= r_ref - REF_W'(1);
                end
            end
            for (int i = 0; i < NUM_FAN_IN; i++) begin
                if (w_we && (w_addr == IDX_W'(i)))
                    r_w[i] <= w_data;
            end
        end
    end

    assign spk        = r_spk;
    assign cur_out    = r_cur;
    assign mem_out    = r_mem;
    assign thr_out    = r_thr;
    assign refrac_out = w_refrac;

endmodule
`default_nettype wire

// File: tb/tb_adaptive_lif_neuron.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adaptive_lif_neuron
//  Description : Directed table plus random stimulus against a reference model.
//  Revision    : 1.0
// ============================================================================
module tb_adaptive_lif_neuron;

    localparam int ORI = 32;
    localparam int ADP = 2;
    localparam int RF  = 2;
    localparam int SH  = 2;

    logic                clk;
    logic                reset;
    logic                step;
    logic [7:0]          fan_in;
    logic                w_we;
    logic [2:0]          w_addr;
    logic signed [3:0]   w_data;
    logic                spk_o [2];
    logic signed [7:0]   cur_o [2];
    logic signed [7:0]   mem_o [2];
    logic [7:0]          thr_o [2];
    logic                ref_o [2];

    int n_vec = 0;
    int n_err = 0;

    int m_cur [2];
    int m_mem [2];
    int m_thr [2];
    int m_ref [2];
    int m_spk [2];
    int m_w   [8];

    typedef struct {
        bit                rst;
        bit                stp;
        logic [7:0]        fan;
        bit                we;
        logic [2:0]        addr;
        logic signed [3:0] data;
        int                cur;
        int                mem;
        int                thr;
        int                spk;
        int                rf;
        int                mem_sub;
    } vec_t;

    vec_t tbl [$];

    adaptive_lif_neuron #(.RESET_MODE(0)) dut (
        .clk(clk), .reset(reset), .step(step), .fan_in(fan_in),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .spk(spk_o[0]), .cur_out(cur_o[0]), .mem_out(mem_o[0]),
        .thr_out(thr_o[0]), .refrac_out(ref_o[0])
    );

    adaptive_lif_neuron #(.RESET_MODE(1)) dut_sub (
        .clk(clk), .reset(reset), .step(step), .fan_in(fan_in),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .spk(spk_o[1]), .cur_out(cur_o[1]), .mem_out(mem_o[1]),
        .thr_out(thr_o[1]), .refrac_out(ref_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference neuron: integer arithmetic straight from the update rules.
    task automatic model_edge(input bit rs, input bit st, input logic [7:0] fan,
                              input bit we, input logic [2:0] addr, input logic signed [3:0] data);
        int syn, cn, mc, td, dec;
        bit fire;
        if (rs) begin
            for (int k = 0; k < 2; k++) begin
                m_cur[k] = 0; m_mem[k] = 0; m_thr[k] = ORI; m_ref[k] = 0; m_spk[k] = 0;
            end
            for (int i = 0; i < 8; i++) m_w[i] = 1;
            return;
        end
        for (int k = 0; k < 2; k++) m_spk[k] = 0;
        if (st) begin
            syn = 0;
            for (int i = 0; i < 8; i++) if (fan[i]) syn += m_w[i];
            for (int k = 0; k < 2; k++) begin
                cn = clampi(m_cur[k] - (m_cur[k] >>> SH) + syn, -128, 127);
                if (m_ref[k] > 0) begin
                    mc = 0; fire = 0; m_ref[k]--;
                end else begin
                    mc = clampi(m_mem[k] - (m_mem[k] >>> SH) + cn, -128, 127);
                    if (mc < 0) mc = 0;
                    fire = (mc >= m_thr[k]);
                end
                if (m_thr[k] > ORI) begin
                    dec = (m_thr[k] - ORI) >> SH;
                    if (dec < 1) dec = 1;
                    td = m_thr[k] - dec;
                end else begin
                    td = ORI;
                end
                if (fire) begin
                    m_mem[k] = (k == 1) ? mc - m_thr[k] : 0;
                    m_thr[k] = (td + ADP > 255) ? 255 : td + ADP;
                    m_ref[k] = RF;
                    m_spk[k] = 1;
                end else begin
                    m_mem[k] = mc;
                    m_thr[k] = td;
                end
                m_cur[k] = cn;
            end
        end
        if (we) m_w[addr] = data;
    endtask

    task automatic apply(input bit rs, input bit st, input logic [7:0] fan,
                         input bit we, input logic [2:0] addr, input logic signed [3:0] data);
        reset = rs; step = st; fan_in = fan; w_we = we; w_addr = addr; w_data = data;
        @(posedge clk);
        model_edge(rs, st, fan, we, addr, data);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("model_cur[%0d]", k), int'(cur_o[k]), m_cur[k]);
            check($sformatf("model_mem[%0d]", k), int'(mem_o[k]), m_mem[k]);
            check($sformatf("model_thr[%0d]", k), int'(thr_o[k]), m_thr[k]);
            check($sformatf("model_spk[%0d]", k), int'(spk_o[k]), m_spk[k]);
            check($sformatf("model_ref[%0d]", k), int'(ref_o[k]), (m_ref[k] != 0) ? 1 : 0);
        end
    endtask

    task automatic row(input bit rs, input bit st, input logic [7:0] fan, input bit we,
                       input logic [2:0] addr, input logic signed [3:0] data,
                       input int c, input int m, input int t, input int s, input int r, input int ms);
        vec_t v;
        v = '{rs, st, fan, we, addr, data, c, m, t, s, r, ms};
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; step = 1'b0; fan_in = '0; w_we = 1'b0; w_addr = '0; w_data = '0;

        // Plain counting, fire, refractory, integration resumes.
        row(1, 0, 8'h00, 0, 0, 0,   0,  0, 32, 0, 0,  0);
        row(0, 1, 8'hFF, 0, 0, 0,   8,  8, 32, 0, 0,  8);
        row(0, 1, 8'hFF, 0, 0, 0,  14, 20, 32, 0, 0, 20);
        row(0, 1, 8'hFF, 0, 0, 0,  19,  0, 34, 1, 1,  2);
        row(0, 1, 8'hFF, 0, 0, 0,  23,  0, 33, 0, 1,  0);
        row(0, 1, 8'hFF, 0, 0, 0,  26,  0, 32, 0, 0,  0);
        row(0, 1, 8'h00, 0, 0, 0,  20, 20, 32, 0, 0, 20);
        row(0, 0, 8'hFF, 0, 0, 0,  20, 20, 32, 0, 0, 20);
        // Threshold relaxes to rest with no input, then re-adapts.
        row(1, 0, 8'h00, 0, 0, 0,   0,  0, 32, 0, 0,  0);
        row(0, 1, 8'hFF, 0, 0, 0,   8,  8, 32, 0, 0, -1);
        row(0, 1, 8'hFF, 0, 0, 0,  14, 20, 32, 0, 0, -1);
        row(0, 1, 8'hFF, 0, 0, 0,  19,  0, 34, 1, 1,  2);
        row(0, 1, 8'h00, 0, 0, 0,  15,  0, 33, 0, 1, -1);
        row(0, 1, 8'h00, 0, 0, 0,  12,  0, 32, 0, 0, -1);
        row(0, 1, 8'h00, 0, 0, 0,   9,  9, 32, 0, 0, -1);
        row(0, 1, 8'h00, 0, 0, 0,   7, 14, 32, 0, 0, -1);
        row(0, 1, 8'hFF, 0, 0, 0,  14, 25, 32, 0, 0, -1);
        row(0, 1, 8'hFF, 0, 0, 0,  19,  0, 34, 1, 1,  6);
        // Weights 7: positive saturation of cur.
        row(1, 0, 8'h00, 0, 0, 0,   0,  0, 32, 0, 0,  0);
        for (int i = 0; i < 8; i++) row(0, 0, 8'h00, 1, 3'(i), 4'sd7, 0, 0, 32, 0, 0, 0);
        row(0, 1, 8'hFF, 0, 0, 0,  56,  0, 34, 1, 1, 24);
        row(0, 1, 8'hFF, 0, 0, 0,  98,  0, 33, 0, 1, -1);
        row(0, 1, 8'hFF, 0, 0, 0, 127,  0, 32, 0, 0, -1);
        row(0, 1, 8'hFF, 0, 0, 0, 127,  0, 34, 1, 1, 95);
        row(0, 1, 8'hFF, 0, 0, 0, 127,  0, 33, 0, 1, -1);
        // Weights -8 written while refractory: negative saturation, mem floored.
        for (int i = 0; i < 8; i++) row(0, 0, 8'h00, 1, 3'(i), -4'sd8, 127, 0, 33, 0, 1, -1);
        row(0, 1, 8'hFF, 0, 0, 0,   32, 0, 32, 0, 0, -1);
        row(0, 1, 8'hFF, 0, 0, 0,  -40, 0, 32, 0, 0,  0);
        row(0, 1, 8'hFF, 0, 0, 0,  -94, 0, 32, 0, 0,  0);
        row(0, 1, 8'hFF, 0, 0, 0, -128, 0, 32, 0, 0,  0);
        row(0, 1, 8'hFF, 0, 0, 0, -128, 0, 32, 0, 0,  0);
        // Same-cycle write uses the old weight; reset mid-refractory wins over step/write.
        row(1, 0, 8'h00, 0, 0, 0,   0,  0, 32, 0, 0,  0);
        row(0, 1, 8'h01, 1, 0, 4'sd5, 1, 1, 32, 0, 0, 1);
        row(0, 1, 8'h01, 0, 0, 0,   6,  7, 32, 0, 0,  7);
        row(0, 1, 8'hFF, 0, 0, 0,  17, 23, 32, 0, 0, 23);
        row(0, 1, 8'hFF, 0, 0, 0,  25,  0, 34, 1, 1, 11);
        row(1, 1, 8'hFF, 1, 0, 4'sd7, 0, 0, 32, 0, 0, 0);
        row(0, 1, 8'hFF, 0, 0, 0,   8,  8, 32, 0, 0,  8);

        @(posedge clk); #1;
        foreach (tbl[j]) begin
            apply(tbl[j].rst, tbl[j].stp, tbl[j].fan, tbl[j].we, tbl[j].addr, tbl[j].data);
            check($sformatf("tbl%0d_cur", j), int'(cur_o[0]), tbl[j].cur);
            check($sformatf("tbl%0d_mem", j), int'(mem_o[0]), tbl[j].mem);
            check($sformatf("tbl%0d_thr", j), int'(thr_o[0]), tbl[j].thr);
            check($sformatf("tbl%0d_spk", j), int'(spk_o[0]), tbl[j].spk);
            check($sformatf("tbl%0d_ref", j), int'(ref_o[0]), tbl[j].rf);
            if (tbl[j].mem_sub >= 0)
                check($sformatf("tbl%0d_mem_sub", j), int'(mem_o[1]), tbl[j].mem_sub);
        end

        // Spike is a single pulse: an idle cycle after a fire drops it and holds state.
        apply(1, 0, 8'h00, 0, 0, 0);
        repeat (3) apply(0, 1, 8'hFF, 0, 0, 0);
        check("fire_pulse", int'(spk_o[0]), 1);
        apply(0, 0, 8'hFF, 0, 0, 0);
        check("idle_spk", int'(spk_o[0]), 0);
        check("idle_thr", int'(thr_o[0]), 34);
        check("idle_ref", int'(ref_o[0]), 1);
        check("idle_cur", int'(cur_o[0]), 19);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            apply(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 75), 8'($urandom),
                  ($urandom_range(0, 99) < 25), 3'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
